// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: single FSM that walks the hue wheel in six ramp phases and
// produces the three RGB pwm duty values. Exactly one channel ramps per phase.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       1 = step timer runs and ramp advances, 0 = freeze (timer clears)
//   restart      synchronous pulse, reloads the reset state
//   brightness   global brightness (only when RGB_BRIGHTNESS_EN is defined)
//   r/g/b_pwm_value  duty values to the pwm instances
//   phase        current phase code 0..5
//   step_tick    one-cycle pulse after every ramp step
//   cycle_done   one-cycle pulse after the 5 -> 0 phase wrap
//
// Optional feature macro: RGB_BRIGHTNESS_EN (adds brightness scaling, +1 cycle on duties).
module rgb_hue_sequencer #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_CYCLES  = 12000,
  parameter int unsigned INC          = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            restart,
`ifdef RGB_BRIGHTNESS_EN
  input  logic [7:0]                      brightness,
`endif
  output logic [$clog2(PWM_INTERVAL)-1:0] r_pwm_value,
  output logic [$clog2(PWM_INTERVAL)-1:0] g_pwm_value,
  output logic [$clog2(PWM_INTERVAL)-1:0] b_pwm_value,
  output logic [2:0]                      phase,
  output logic                            step_tick,
  output logic                            cycle_done
);

  localparam int unsigned W        = $clog2(PWM_INTERVAL);
  localparam int unsigned DUTY_MAX = PWM_INTERVAL - 1;
  localparam int unsigned TW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  if (INC < 1 || INC > DUTY_MAX) begin : g_bad_inc
    $error("rgb_hue_sequencer: INC must be in 1..PWM_INTERVAL-1");
  end

  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_e;

  phase_e        state_q, state_nxt;
  logic [W-1:0]  r_q, g_q, b_q, r_nxt, g_nxt, b_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          tick_nxt, done_nxt;

  // Ramp datapath signals
  logic          tick;
  logic          legal;
  logic          ramp_up;
  logic [1:0]    ramp_sel;     // 0 = red, 1 = green, 2 = blue
  logic [W-1:0]  cur;
  logic [W:0]    up_sum;
  logic [W-1:0]  new_val;
  logic          at_bound;

  // State, duty, timer and pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PH_G_UP;
      r_q        <= W'(DUTY_MAX);
      g_q        <= '0;
      b_q        <= '0;
      timer_q    <= '0;
      step_tick  <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      r_q        <= r_nxt;
      g_q        <= g_nxt;
      b_q        <= b_nxt;
      timer_q    <= timer_nxt;
      step_tick  <= tick_nxt;
      cycle_done <= done_nxt;
    end
  end

  // Next-state, ramp arithmetic and timer
  always_comb begin
    state_nxt = state_q;
    r_nxt     = r_q;
    g_nxt     = g_q;
    b_nxt     = b_q;
    timer_nxt = timer_q;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    legal     = 1'b1;
    ramp_up   = 1'b1;
    ramp_sel  = 2'd1;

    tick = enable && (timer_q == TW'(STEP_CYCLES - 1));
    if (!enable || tick) timer_nxt = '0;
    else                 timer_nxt = timer_q + TW'(1);

    case (state_q)
      PH_G_UP: begin ramp_sel = 2'd1; ramp_up = 1'b1; end
      PH_R_DN: begin ramp_sel = 2'd0; ramp_up = 1'b0; end
      PH_B_UP: begin ramp_sel = 2'd2; ramp_up = 1'b1; end
      PH_G_DN: begin ramp_sel = 2'd1; ramp_up = 1'b0; end
      PH_R_UP: begin ramp_sel = 2'd0; ramp_up = 1'b1; end
      PH_B_DN: begin ramp_sel = 2'd2; ramp_up = 1'b0; end
      default: legal = 1'b0;
    endcase

    case (ramp_sel)
      2'd0:    cur = r_q;
      2'd1:    cur = g_q;
      default: cur = b_q;
    endcase

    // Saturating step computed one bit wider so the increment cannot wrap
    up_sum = {1'b0, cur} + (W+1)'(INC);
    if (ramp_up) new_val = (up_sum > (W+1)'(DUTY_MAX)) ? W'(DUTY_MAX) : up_sum[W-1:0];
    else         new_val = (cur < W'(INC)) ? '0 : cur - W'(INC);
    at_bound = ramp_up ? (new_val == W'(DUTY_MAX)) : (new_val == '0);

    if (restart || !legal) begin
      state_nxt = PH_G_UP;
      r_nxt     = W'(DUTY_MAX);
      g_nxt     = '0;
      b_nxt     = '0;
      timer_nxt = '0;
    end else if (tick) begin
      tick_nxt = 1'b1;
      case (ramp_sel)
        2'd0:    r_nxt = new_val;
        2'd1:    g_nxt = new_val;
        default: b_nxt = new_val;
      endcase
      if (at_bound) begin
        state_nxt = (state_q == PH_B_DN) ? PH_G_UP : phase_e'(3'(state_q + 3'd1));
        done_nxt  = (state_q == PH_B_DN);
      end
    end
  end

  assign phase = state_q;

`ifdef RGB_BRIGHTNESS_EN
  logic [8:0]   bright_p1;
  logic [W+8:0] r_prod, g_prod, b_prod;

  // Scale by (brightness+1)/256; brightness=255 is an exact passthrough
  always_comb begin
    bright_p1 = {1'b0, brightness} + 9'd1;
    r_prod    = (W+9)'(r_q) * (W+9)'(bright_p1);
    g_prod    = (W+9)'(g_q) * (W+9)'(bright_p1);
    b_prod    = (W+9)'(b_q) * (W+9)'(bright_p1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_value <= '0;
      g_pwm_value <= '0;
      b_pwm_value <= '0;
    end else begin
      r_pwm_value <= r_prod[W+7:8];
      g_pwm_value <= g_prod[W+7:8];
      b_pwm_value <= b_prod[W+7:8];
    end
  end
`else
  assign r_pwm_value = r_q;
  assign g_pwm_value = g_q;
  assign b_pwm_value = b_q;
`endif

endmodule
